// File: rtl/snn_mac_lif_array.sv
// Array of leaky integrate-and-fire neurons sharing one latched binary input vector.
// One input is accumulated per cycle into every neuron in parallel; FIRE applies leak, bias and refractory hold.
module snn_mac_lif_array #(
    parameter int NUM_INPUTS  = 25,
    parameter int NUM_NEURONS = 4,
    parameter int W_W         = 8,
    parameter int ACC_W       = 16,
    parameter int THRESH      = 64,
    parameter int LEAK_SHIFT  = 3,
    parameter int REFRAC      = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  pulse,
    input  logic [NUM_INPUTS-1:0]                 pixelsIn,
    input  logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0] weightsIn,
    input  logic [NUM_NEURONS*W_W-1:0]            bias,
    output logic                                  busy,
    output logic                                  spk_valid,
    output logic [NUM_NEURONS-1:0]                spk_out
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int RF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int VX_W  = ACC_W + 2;
    localparam logic signed [VX_W-1:0] V_MAX    = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [VX_W-1:0] V_THR    = VX_W'(THRESH);
    localparam logic [RF_W-1:0]        RF_LOAD  = RF_W'(REFRAC);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_INPUTS-1:0]    pix_q, pix_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_NEURONS];
    logic signed [ACC_W-1:0]  acc_d [NUM_NEURONS];
    logic signed [ACC_W-1:0]  v_q [NUM_NEURONS];
    logic signed [ACC_W-1:0]  v_d [NUM_NEURONS];
    logic [RF_W-1:0]          refrac_q [NUM_NEURONS];
    logic [RF_W-1:0]          refrac_d [NUM_NEURONS];
    logic                     busy_q, busy_d;
    logic                     spk_valid_q, spk_valid_d;
    logic [NUM_NEURONS-1:0]   spk_out_q, spk_out_d;
    logic signed [VX_W-1:0]   v_next [NUM_NEURONS];

    // Signed add that pins at the ACC_W rails instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [W_W-1:0]   w);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-W_W){w[W_W-1]}}, w};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic signed [VX_W-1:0] lif_next(input logic signed [ACC_W-1:0] v,
                                                        input logic signed [ACC_W-1:0] a,
                                                        input logic signed [W_W-1:0]   b);
        logic signed [VX_W-1:0] vx, leak, sum;
        vx   = {{2{v[ACC_W-1]}}, v};
        leak = (LEAK_SHIFT == 0) ? '0 : (vx >>> LEAK_SHIFT);
        sum  = vx - leak + {{2{a[ACC_W-1]}}, a} + {{(VX_W-W_W){b[W_W-1]}}, b};
        if (sum < 0)     return '0;
        if (sum > V_MAX) return V_MAX;
        return sum;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        pix_d       = pix_q;
        acc_d       = acc_q;
        v_d         = v_q;
        refrac_d    = refrac_q;
        busy_d      = busy_q;
        spk_valid_d = 1'b0;
        spk_out_d   = spk_out_q;
        for (int n = 0; n < NUM_NEURONS; n++)
            v_next[n] = lif_next(v_q[n], acc_q[n], bias[n*W_W +: W_W]);

        case (state_q)
            S_IDLE: begin
                if (pulse) begin
                    pix_d   = pixelsIn;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ACCUM;
                    for (int n = 0; n < NUM_NEURONS; n++)
                        acc_d[n] = '0;
                end
            end
            S_ACCUM: begin
                for (int n = 0; n < NUM_NEURONS; n++)
                    if (pix_q[idx_q])
                        acc_d[n] = sat_add(acc_q[n],
                                           weightsIn[(n*NUM_INPUTS + int'(idx_q))*W_W +: W_W]);
                if (idx_q == IDX_LAST) state_d = S_FIRE;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_FIRE: begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (refrac_q[n] != '0) begin
                        refrac_d[n]  = refrac_q[n] - 1'b1;
                        v_d[n]       = '0;
                        spk_out_d[n] = 1'b0;
                    end else if (v_next[n] >= V_THR) begin
                        refrac_d[n]  = RF_LOAD;
                        v_d[n]       = '0;
                        spk_out_d[n] = 1'b1;
                    end else begin
                        v_d[n]       = v_next[n][ACC_W-1:0];
                        spk_out_d[n] = 1'b0;
                    end
                end
                spk_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pix_q       <= '0;
            busy_q      <= 1'b0;
            spk_valid_q <= 1'b0;
            spk_out_q   <= '0;
            // NOTE: these per-neuron arrays are plain flops, not RAM, so they are cleared in reset.
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc_q[n]    <= '0;
                v_q[n]      <= '0;
                refrac_q[n] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_q       <= pix_d;
            busy_q      <= busy_d;
            spk_valid_q <= spk_valid_d;
            spk_out_q   <= spk_out_d;
            acc_q       <= acc_d;
            v_q         <= v_d;
            refrac_q    <= refrac_d;
        end
    end

    assign busy      = busy_q;
    assign spk_valid = spk_valid_q;
    assign spk_out   = spk_out_q;

endmodule

// File: tb/tb_snn_mac_lif_array.sv
// Self-checking bench for snn_mac_lif_array: per-feature tasks compared against a
// timestep-level arithmetic model of the neuron array.
module tb_snn_mac_lif_array;
    localparam int NI = 25;
    localparam int NN = 4;
    localparam int WW = 8;
    localparam int AW = 16;
    localparam int TH = 64;
    localparam int LS = 3;
    localparam int RF = 2;
    localparam int ACC_MAX = 2 ** (AW - 1) - 1;
    localparam int SAT_MAX = 2047;

    logic              clk = 1'b0;
    logic              reset;
    logic              pulse;
    logic [NI-1:0]     pixels_in;
    logic [NN*NI*WW-1:0] weights_in;
    logic [NN*WW-1:0]  bias_in;
    logic              busy, spk_valid;
    logic [NN-1:0]     spk_out;

    logic              pulse_s;
    logic              busy_s, valid_s;
    logic [NN-1:0]     spk_s;

    int w_tb [NN][NI];
    int b_tb [NN];
    int mv [NN];
    int mr [NN];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        weights_in = '0;
        bias_in    = '0;
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++)
                weights_in[(n*NI+i)*WW +: WW] = WW'(w_tb[n][i]);
            bias_in[n*WW +: WW] = WW'(b_tb[n]);
        end
    end

    snn_mac_lif_array dut (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse),
        .pixelsIn  (pixels_in),
        .weightsIn (weights_in),
        .bias      (bias_in),
        .busy      (busy),
        .spk_valid (spk_valid),
        .spk_out   (spk_out)
    );

    snn_mac_lif_array #(.ACC_W(12), .THRESH(SAT_MAX), .LEAK_SHIFT(0)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse_s),
        .pixelsIn  ({NI{1'b1}}),
        .weightsIn ({(NN*NI){8'sd127}}),
        .bias      ({NN{8'sd127}}),
        .busy      (busy_s),
        .spk_valid (valid_s),
        .spk_out   (spk_s)
    );

    // One timestep of the neuron array, straight from the integrate/leak/fire rules.
    function automatic logic [NN-1:0] model_step(input logic [NI-1:0] pix);
        logic [NN-1:0] s;
        int acc, vn;
        s = '0;
        for (int n = 0; n < NN; n++) begin
            acc = 0;
            for (int i = 0; i < NI; i++) begin
                if (pix[i]) begin
                    acc = acc + w_tb[n][i];
                    if (acc > ACC_MAX)         acc = ACC_MAX;
                    else if (acc < -ACC_MAX-1) acc = -ACC_MAX - 1;
                end
            end
            if (mr[n] > 0) begin
                mr[n] = mr[n] - 1;
                mv[n] = 0;
            end else begin
                vn = mv[n] - (mv[n] / (2 ** LS)) + acc + b_tb[n];
                if (vn < 0)       vn = 0;
                if (vn > ACC_MAX) vn = ACC_MAX;
                if (vn >= TH) begin
                    s[n]  = 1'b1;
                    mv[n] = 0;
                    mr[n] = RF;
                end else begin
                    mv[n] = vn;
                end
            end
        end
        return s;
    endfunction

    task automatic set_weights(input int w, input int b);
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) w_tb[n][i] = w;
            b_tb[n] = b;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < NN; n++) begin
            mv[n] = 0;
            mr[n] = 0;
        end
    endtask

    task automatic do_step(input logic [NI-1:0] pix, output logic [NN-1:0] spk, output bit got);
        @(negedge clk);
        pixels_in = pix;
        pulse     = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        got   = 1'b0;
        spk   = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (spk_valid) begin
                got = 1'b1;
                spk = spk_out;
            end
        end
    endtask

    task automatic do_step_sat(output logic [NN-1:0] spk, output bit got);
        @(negedge clk);
        pulse_s = 1'b1;
        @(negedge clk);
        pulse_s = 1'b0;
        got = 1'b0;
        spk = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (valid_s) begin
                got = 1'b1;
                spk = spk_s;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (spk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", spk_valid); end
        checks++;
        if (spk_out !== '0) begin errors++; $display("FAIL reset_spk: got %b want 0000", spk_out); end
        checks++;
        if (busy_s !== 1'b0 || valid_s !== 1'b0) begin
            errors++; $display("FAIL reset_sat: busy %b valid %b want 0 0", busy_s, valid_s);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_integrate_fire();
        logic [NN-1:0] spk, expv;
        bit got;
        apply_reset();
        set_weights(1, 0);
        for (int p = 1; p <= 6; p++) begin
            expv = model_step('1);
            do_step('1, spk, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL integrate_p%0d: no spk_valid within budget", p);
            end else if (spk !== expv) begin
                errors++; $display("FAIL integrate_p%0d: spk_out %b want %b", p, spk, expv);
            end
            checks++;
            if (spk !== ((p == 3) ? 4'b1111 : 4'b0000)) begin
                errors++; $display("FAIL integrate_pattern_p%0d: spk_out %b", p, spk);
            end
        end
    endtask

    task automatic test_timing();
        logic [NI-1:0] pix;
        logic [NN-1:0] spk, expv;
        int nb, nv, first;
        pix  = NI'($urandom);
        expv = model_step(pix);
        nb = 0; nv = 0; first = 0; spk = '0;
        @(negedge clk);
        pixels_in = pix;
        pulse     = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) pulse = 1'b0;
            if (n == 5) pulse = 1'b1;
            if (n == 6) pulse = 1'b0;
            if (busy) nb++;
            if (spk_valid) begin
                nv++;
                if (first == 0) begin
                    first = n;
                    spk   = spk_out;
                end
            end
        end
        checks++;
        if (first !== 27) begin errors++; $display("FAIL timing_latency: %0d cycles want 27", first); end
        checks++;
        if (nv !== 1) begin errors++; $display("FAIL timing_valid_count: %0d strobes want 1", nv); end
        checks++;
        if (nb !== 26) begin errors++; $display("FAIL timing_busy: %0d cycles want 26", nb); end
        checks++;
        if (spk !== expv) begin errors++; $display("FAIL timing_spk: spk_out %b want %b", spk, expv); end
    endtask

    task automatic test_independence();
        logic [NN-1:0] spk, expv;
        logic [NN-1:0] want [3];
        bit got;
        want[0] = 4'b0001;
        want[1] = 4'b0000;
        want[2] = 4'b1000;
        apply_reset();
        set_weights(0, 0);
        w_tb[0][0] = 64;
        b_tb[3]    = -128;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                w_tb[0][0] = 0;
                b_tb[3]    = 64;
            end
            expv = model_step(25'h0000001);
            do_step(25'h0000001, spk, got);
            checks++;
            if (!got || spk !== expv) begin
                errors++; $display("FAIL indep_model_%0d: spk_out %b got_valid %0d want %b", p, spk, got, expv);
            end
            checks++;
            if (spk !== want[p]) begin
                errors++; $display("FAIL indep_const_%0d: spk_out %b want %b", p, spk, want[p]);
            end
        end
    endtask

    task automatic test_pixel_latch();
        logic [NI-1:0] pix;
        logic [NN-1:0] spk, expv;
        bit got;
        apply_reset();
        set_weights(5, 0);
        for (int p = 0; p < 3; p++) begin
            pix = (p == 0) ? 25'h0001FFF : NI'($urandom);
            if (p > 0)
                for (int n = 0; n < NN; n++)
                    for (int i = 0; i < NI; i++) w_tb[n][i] = int'($urandom_range(14));
            expv = model_step(pix);
            @(negedge clk);
            pixels_in = pix;
            pulse     = 1'b1;
            @(negedge clk);
            pulse     = 1'b0;
            pixels_in = ~pix;
            got = 1'b0;
            spk = '0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                if (spk_valid) begin
                    got = 1'b1;
                    spk = spk_out;
                end
            end
            checks++;
            if (!got || spk !== expv) begin
                errors++; $display("FAIL latch_%0d: spk_out %b got_valid %0d want %b", p, spk, got, expv);
            end
        end
    endtask

    task automatic test_random();
        logic [NI-1:0] pix;
        logic [NN-1:0] spk, expv;
        bit got;
        apply_reset();
        for (int p = 0; p < 40; p++) begin
            if (p % 10 == 0) begin
                for (int n = 0; n < NN; n++) begin
                    for (int i = 0; i < NI; i++) w_tb[n][i] = int'($urandom_range(40)) - 16;
                    b_tb[n] = int'($urandom_range(60)) - 30;
                end
            end
            pix  = NI'($urandom);
            expv = model_step(pix);
            do_step(pix, spk, got);
            checks++;
            if (!got || spk !== expv) begin
                errors++; $display("FAIL random_%0d: spk_out %b got_valid %0d want %b", p, spk, got, expv);
            end
        end
    endtask

    task automatic test_saturation();
        logic [NN-1:0] spk, expv;
        bit got;
        int sv, sr, acc, vn;
        sv = 0;
        sr = 0;
        for (int p = 0; p < 4; p++) begin
            acc = 0;
            for (int i = 0; i < NI; i++) begin
                acc = acc + 127;
                if (acc > SAT_MAX) acc = SAT_MAX;
            end
            if (sr > 0) begin
                sr   = sr - 1;
                sv   = 0;
                expv = '0;
            end else begin
                vn = sv + acc + 127;
                if (vn > SAT_MAX) vn = SAT_MAX;
                if (vn >= SAT_MAX) begin
                    expv = '1;
                    sv   = 0;
                    sr   = RF;
                end else begin
                    expv = '0;
                    sv   = vn;
                end
            end
            do_step_sat(spk, got);
            checks++;
            if (!got || spk !== expv) begin
                errors++; $display("FAIL sat_%0d: spk_out %b got_valid %0d want %b", p, spk, got, expv);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [NN-1:0] spk, expv;
        bit got;
        int nv;
        apply_reset();
        set_weights(1, 0);
        for (int p = 1; p <= 3; p++) begin
            expv = model_step('1);
            do_step('1, spk, got);
            checks++;
            if (!got || spk !== expv) begin
                errors++; $display("FAIL areset_pre_%0d: spk_out %b want %b", p, spk, expv);
            end
        end
        @(negedge clk);
        pixels_in = '1;
        pulse     = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++;
        if (spk_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", spk_valid); end
        checks++;
        if (spk_out !== '0) begin errors++; $display("FAIL areset_spk: got %b want 0000", spk_out); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < NN; n++) begin
            mv[n] = 0;
            mr[n] = 0;
        end
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (spk_valid) nv++;
        end
        checks++;
        if (nv !== 0) begin errors++; $display("FAIL areset_no_valid: %0d strobes want 0", nv); end
        for (int p = 1; p <= 3; p++) begin
            expv = model_step('1);
            do_step('1, spk, got);
            checks++;
            if (!got || spk !== expv) begin
                errors++; $display("FAIL areset_post_%0d: spk_out %b want %b", p, spk, expv);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        pulse     = 1'b0;
        pulse_s   = 1'b0;
        pixels_in = '0;
        set_weights(0, 0);
        for (int n = 0; n < NN; n++) begin
            mv[n] = 0;
            mr[n] = 0;
        end
        test_reset();
        test_integrate_fire();
        test_timing();
        test_independence();
        test_pixel_latch();
        test_random();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
